// File: rtl/adder_vec_checker.sv
// adder_vec_checker: checks streamed adder vectors against a golden sum and tallies the results
module adder_vec_checker #(
  parameter int WIDTH = 4,
  parameter int NUM_VECTORS = 128,
  localparam int CW = $clog2(NUM_VECTORS + 1)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic           cin,
  input  logic [WIDTH:0] sum,
  output logic           busy,
  output logic           done,
  output logic           all_pass,
  output logic [CW-1:0]  pass_count,
  output logic [CW-1:0]  fail_count,
  output logic [CW-1:0]  first_fail_idx,
  output logic [WIDTH:0] first_fail_got,
  output logic [WIDTH:0] first_fail_exp,
  output logic           first_fail_vld
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_next;
  logic [CW-1:0] idx;
  logic [WIDTH:0] exp;
  logic accept, last, begin_run, mismatch;
  assign in_ready = state == RUN;
  assign busy = state == RUN;
  assign done = state == DONE;
  assign all_pass = done && fail_count == '0;
  assign accept = in_valid && in_ready;
  assign last = idx == CW'(NUM_VECTORS - 1);
  assign begin_run = start && state != RUN;
  assign exp = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
  assign mismatch = sum != exp;
  // state register
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_next;
  // next state: start is only honoured outside RUN, so it never collides with an accept
  always_comb begin
    state_next = begin_run ? RUN : (accept && last) ? DONE : state;
  end
  // counters, vector index and first-mismatch capture
  always_ff @(posedge clk or posedge reset)
    if (reset || begin_run) begin
      idx <= '0;
      pass_count <= '0;
      fail_count <= '0;
      first_fail_idx <= '0;
      first_fail_got <= '0;
      first_fail_exp <= '0;
      first_fail_vld <= 1'b0;
    end else if (accept) begin
      idx <= idx + 1'b1;
      if (mismatch) begin
        fail_count <= fail_count + 1'b1;
        if (!first_fail_vld) begin
          first_fail_idx <= idx;
          first_fail_got <= sum;
          first_fail_exp <= exp;
          first_fail_vld <= 1'b1;
        end
      end else begin
        pass_count <= pass_count + 1'b1;
      end
    end
endmodule

// File: tb/tb_adder_vec_checker.sv
// tb_adder_vec_checker: randomized directed run of the checker against a list-based reference model
module tb_adder_vec_checker;
  localparam int WIDTH = 4;
  localparam int N = 128;
  localparam int CW = $clog2(N + 1);
  logic clk = 0, reset = 1, start = 0, in_valid = 0, cin = 0;
  logic [WIDTH-1:0] a = 0, b = 0;
  logic [WIDTH:0] sum = 0;
  logic in_ready, busy, done, all_pass, first_fail_vld;
  logic [CW-1:0] pass_count, fail_count, first_fail_idx;
  logic [WIDTH:0] first_fail_got, first_fail_exp;
  int checks = 0, errors = 0;
  int q_got[$], q_exp[$];
  bit running = 0, done_m = 0;

  always #5 clk = ~clk;

  adder_vec_checker #(.WIDTH(WIDTH), .NUM_VECTORS(N)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sum(sum), .busy(busy), .done(done), .all_pass(all_pass),
    .pass_count(pass_count), .fail_count(fail_count), .first_fail_idx(first_fail_idx),
    .first_fail_got(first_fail_got), .first_fail_exp(first_fail_exp), .first_fail_vld(first_fail_vld)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  // expected outputs are derived by scanning the list of accepted vectors
  task automatic check_all();
    int p = 0, f = 0, fi = 0, fg = 0, fe = 0;
    bit fv = 0;
    foreach (q_got[i])
      if (q_got[i] == q_exp[i]) p++;
      else begin
        f++;
        if (!fv) begin fv = 1; fi = i; fg = q_got[i]; fe = q_exp[i]; end
      end
    chk("in_ready", in_ready, running);
    chk("busy", busy, running);
    chk("done", done, done_m);
    chk("all_pass", all_pass, done_m && f == 0);
    chk("pass_count", pass_count, p);
    chk("fail_count", fail_count, f);
    chk("first_fail_vld", first_fail_vld, fv);
    chk("first_fail_idx", first_fail_idx, fi);
    chk("first_fail_got", first_fail_got, fg);
    chk("first_fail_exp", first_fail_exp, fe);
  endtask

  task automatic cycle(input bit v, input bit st, input logic [3:0] ta, input logic [3:0] bv,
                       input logic tc, input logic [4:0] ts);
    in_valid = v; start = st; a = ta; b = bv; cin = tc; sum = ts;
    @(posedge clk);
    if (running && v) begin
      q_got.push_back(int'(ts));
      q_exp.push_back(int'(ta) + int'(bv) + int'(tc));
      if (q_got.size() == N) begin running = 0; done_m = 1; end
    end else if (st && !running) begin
      running = 1; done_m = 0; q_got.delete(); q_exp.delete();
    end
    @(negedge clk);
    in_valid = 0; start = 0;
    check_all();
  endtask

  task automatic rvec(input bit bad, output logic [3:0] ta, output logic [3:0] bv,
                      output logic tc, output logic [4:0] ts);
    int e;
    ta = 4'($urandom); bv = 4'($urandom); tc = 1'($urandom);
    e = int'(ta) + int'(bv) + int'(tc);
    ts = bad ? 5'(e + 1 + int'($urandom_range(0, 30))) : 5'(e);
  endtask

  task automatic stream(input int upto, input int gap_pct, input int bad1, input int bad2, input int start_at);
    logic [3:0] ta, bv; logic tc; logic [4:0] ts;
    int k, guard = 0;
    bit v, st;
    while (q_got.size() < upto && guard < 4000) begin
      k = q_got.size();
      rvec(k == bad1 || k == bad2, ta, bv, tc, ts);
      v = int'($urandom_range(0, 99)) >= gap_pct;
      st = k == start_at && v;
      cycle(v, st, ta, bv, tc, ts);
      guard++;
    end
    chk("stream_len", q_got.size(), upto);
  endtask

  initial begin
    #1;
    check_all();
    @(negedge clk) reset = 0;
    cycle(1, 0, 4'hF, 4'hF, 1, 5'h1F);
    chk("idle_ignored", pass_count, 0);
    // run A: all correct, back-to-back
    cycle(0, 1, 0, 0, 0, 0);
    stream(N, 0, -1, -1, -1);
    chk("A_pass", pass_count, 128);
    chk("A_all_pass", all_pass, 1);
    chk("A_done", done, 1);
    cycle(1, 0, 4'h1, 4'h1, 0, 5'h7);
    chk("A_after_done", fail_count, 0);
    // run B: corners plus mismatches at 5 and 9
    cycle(0, 1, 0, 0, 0, 0);
    chk("B_cleared", pass_count, 0);
    cycle(1, 0, 4'hF, 4'hF, 1, 5'h1F);
    cycle(1, 0, 4'h0, 4'h0, 0, 5'h00);
    chk("B_corners", pass_count, 2);
    stream(5, 0, -1, -1, -1);
    cycle(1, 0, 4'h3, 4'h4, 1, 5'h07);
    stream(N, 0, 9, -1, -1);
    chk("B_fail", fail_count, 2);
    chk("B_pass", pass_count, 126);
    chk("B_idx", first_fail_idx, 5);
    chk("B_got", first_fail_got, 7);
    chk("B_exp", first_fail_exp, 8);
    chk("B_all_pass", all_pass, 0);
    // run C: corner fail, 50% gaps, start ignored mid-run
    cycle(0, 1, 0, 0, 0, 0);
    cycle(1, 0, 4'hF, 4'hF, 1, 5'h0F);
    chk("C_exp", first_fail_exp, 5'h1F);
    stream(N, 50, -1, -1, 60);
    chk("C_pass", pass_count, 127);
    chk("C_fail", fail_count, 1);
    for (int i = 0; i < 5; i++) cycle(1, 0, 4'h2, 4'h2, 0, 5'h1);
    chk("C_after_done", pass_count, 127);
    // run D: start coincides with final accept
    cycle(0, 1, 0, 0, 0, 0);
    stream(N, 30, -1, -1, N - 1);
    chk("D_done", done, 1);
    chk("D_pass", pass_count, 128);
    // run E: reset after 40 accepts, then a clean run
    cycle(0, 1, 0, 0, 0, 0);
    stream(40, 0, 3, -1, -1);
    reset = 1;
    #1;
    running = 0; done_m = 0; q_got.delete(); q_exp.delete();
    check_all();
    chk("E_reset_ready", in_ready, 0);
    @(negedge clk) reset = 0;
    cycle(0, 1, 0, 0, 0, 0);
    stream(N, 20, -1, -1, -1);
    chk("E_all_pass", all_pass, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
